start_stop_conditioner: RTL and testbench

//  Input-side conditioner for the start_stop push-button feeding slot_machine_fsm.

---
 rtl/start_stop_conditioner_if.sv | 40 ++++
 rtl/start_stop_conditioner.sv | 121 ++++++++++++
 tb/tb_start_stop_conditioner.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/start_stop_conditioner_if.sv
// rtl/start_stop_conditioner_if.sv - push-button conditioner signal bundle
//
// Signals:
//   btn_raw          raw asynchronous key pin (driven by the board side)
//   lock             1: suppress press/long-press strobes and toggle updates
//   btn_level        debounced pressed level (1 = pressed)
//   press_pulse      one-cycle strobe on accepted press
//   release_pulse    one-cycle strobe on accepted release
//   long_press_pulse one-cycle strobe, once per press, at the long-press threshold
//   toggle           run/stop level, flips on every unlocked press
// Modports: master drives btn_raw/lock, slave (the conditioner) drives the rest.
interface start_stop_conditioner_if;
    logic btn_raw;
    logic lock;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;
    logic toggle;

    modport master (
        output btn_raw,
        output lock,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_press_pulse,
        input  toggle
    );

    modport slave (
        input  btn_raw,
        input  lock,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_press_pulse,
        output toggle
    );
endinterface

// File: rtl/start_stop_conditioner.sv
// rtl/start_stop_conditioner.sv - synchronizer, debouncer and pulse generator for the start/stop key
//
// Ports:
//   clk  system clock (single domain, fast board clock)
//   rst  synchronous active-low reset
//   btn  start_stop_conditioner_if.slave: btn_raw/lock in; btn_level, press_pulse,
//        release_pulse, long_press_pulse, toggle out (all registered)
module start_stop_conditioner #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int LONG_PRESS_CYCLES = 2500000,
    parameter int ACTIVE_LOW_BTN    = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    start_stop_conditioner_if.slave        btn
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          dcnt;
    logic [HW-1:0]          hcnt;
    logic                   p;
    logic                   s;
    logic                   btn_level_q;
    logic                   press_q;
    logic                   release_q;
    logic                   long_q;
    logic                   toggle_q;

    // Normalize polarity before the synchronizer so everything downstream sees 1 = pressed.
    assign p = (ACTIVE_LOW_BTN != 0) ? ~btn.btn_raw : btn.btn_raw;
    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync        <= '0;
            state       <= IDLE;
            dcnt        <= '0;
            hcnt        <= '0;
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            toggle_q    <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], p};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            // Toggle follows the already-masked strobe, so a locked press never flips it.
            toggle_q  <= toggle_q ^ press_q;

            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        dcnt  <= DEB_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (dcnt == DEB_DONE) begin
                        state       <= PRESSED;
                        press_q     <= ~btn.lock;
                        hcnt        <= '0;
                        btn_level_q <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DEB_ONE;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        dcnt  <= DEB_ONE;
                    end else if (hcnt != HOLD_MAX) begin
                        // Saturating count: the strobe fires only on the step onto the threshold.
                        hcnt <= hcnt + HOLD_ONE;
                        if (hcnt == HOLD_LAST) begin
                            long_q <= ~btn.lock;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    // hcnt is frozen here; a bounce back to PRESSED resumes it.
                    if (s) begin
                        state <= PRESSED;
                    end else if (dcnt == DEB_DONE) begin
                        state       <= IDLE;
                        release_q   <= 1'b1;
                        btn_level_q <= 1'b0;
                    end else begin
                        dcnt <= dcnt + DEB_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign btn.btn_level        = btn_level_q;
    assign btn.press_pulse      = press_q;
    assign btn.release_pulse    = release_q;
    assign btn.long_press_pulse = long_q;
    assign btn.toggle           = toggle_q;
endmodule

// File: tb/tb_start_stop_conditioner.sv
// tb/tb_start_stop_conditioner.sv - self-checking bench for start_stop_conditioner
module tb_start_stop_conditioner;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 10;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    start_stop_conditioner_if bus();

    start_stop_conditioner #(
        .SYNC_STAGES      (SYNC),
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG),
        .ACTIVE_LOW_BTN   (1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: accepted level flips once the synchronized key has disagreed with it for
    // DEB+1 consecutive samples; hold time counts samples spent pressed-and-agreeing.
    logic [SYNC-1:0] m_sq;
    logic            m_level;
    int              m_run;
    int              m_hold;
    logic            m_press;
    logic            m_rel;
    logic            m_long;
    logic            m_toggle;
    logic            m_valid;

    int press_cnt, rel_cnt, long_cnt;
    int press_cyc, rel_cyc, long_cyc;

    initial begin
        m_valid = 1'b0;
        checks = 0;
        failures = 0;
        press_cnt = 0;
        rel_cnt = 0;
        long_cnt = 0;
        press_cyc = -1;
        rel_cyc = -1;
        long_cyc = -1;
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs that edge will sample.
    task automatic step_model(input logic rst_in, input logic raw_in, input logic lock_in);
        logic s;
        int   prev_run;
        if (!rst_in) begin
            m_sq     = '0;
            m_level  = 1'b0;
            m_run    = 0;
            m_hold   = 0;
            m_press  = 1'b0;
            m_rel    = 1'b0;
            m_long   = 1'b0;
            m_toggle = 1'b0;
            m_valid  = 1'b1;
        end else begin
            s        = m_sq[SYNC-1];
            m_toggle = m_toggle ^ m_press;
            m_press  = 1'b0;
            m_rel    = 1'b0;
            m_long   = 1'b0;
            prev_run = m_run;
            m_run    = (s == m_level) ? 0 : m_run + 1;
            if (m_run == DEB + 1) begin
                if (!m_level) begin
                    m_level = 1'b1;
                    m_hold  = 0;
                    m_press = ~lock_in;
                end else begin
                    m_level = 1'b0;
                    m_rel   = 1'b1;
                end
                m_run = 0;
            end else if (m_level && s && prev_run == 0 && m_hold < LONG) begin
                m_hold = m_hold + 1;
                if (m_hold == LONG) m_long = ~lock_in;
            end
            m_sq = {m_sq[SYNC-2:0], ~raw_in};
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check_bit("btn_level", bus.btn_level, m_level);
            check_bit("press_pulse", bus.press_pulse, m_press);
            check_bit("release_pulse", bus.release_pulse, m_rel);
            check_bit("long_press_pulse", bus.long_press_pulse, m_long);
            check_bit("toggle", bus.toggle, m_toggle);
        end
        if (bus.press_pulse === 1'b1) begin press_cnt++; press_cyc = cyc; end
        if (bus.release_pulse === 1'b1) begin rel_cnt++; rel_cyc = cyc; end
        if (bus.long_press_pulse === 1'b1) begin long_cnt++; long_cyc = cyc; end
        step_model(rst, bus.btn_raw, bus.lock);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check_bit({name, "_level"}, bus.btn_level, 1'b0);
        check_bit({name, "_press"}, bus.press_pulse, 1'b0);
        check_bit({name, "_release"}, bus.release_pulse, 1'b0);
        check_bit({name, "_long"}, bus.long_press_pulse, 1'b0);
        check_bit({name, "_toggle"}, bus.toggle, 1'b0);
    endtask

    int t0, t1, tr, pc, rc, lc;

    initial begin
        rst = 1'b0;
        bus.btn_raw = 1'b0;
        bus.lock = 1'b0;

        // 1: reset with key reading "pressed", then idle
        step(3);
        check_all_zero("reset");
        rst = 1'b1;
        bus.btn_raw = 1'b1;
        step(20);
        check_all_zero("idle");

        // 2: clean press and release
        pc = press_cnt; rc = rel_cnt;
        t0 = cyc;
        bus.btn_raw = 1'b0;
        step(12);
        check_int("clean_press_count", press_cnt - pc, 1);
        check_int("clean_press_latency", press_cyc - t0, 7);
        check_bit("clean_level_high", bus.btn_level, 1'b1);
        check_bit("clean_toggle", bus.toggle, 1'b1);
        t1 = cyc;
        bus.btn_raw = 1'b1;
        step(12);
        check_int("clean_release_count", rel_cnt - rc, 1);
        check_int("clean_release_latency", rel_cyc - t1, 7);
        check_bit("clean_level_low", bus.btn_level, 1'b0);

        // 3: bouncing press rejected, then release bounce yields one release
        pc = press_cnt; rc = rel_cnt;
        bus.btn_raw = 1'b0; step(3);
        bus.btn_raw = 1'b1; step(1);
        bus.btn_raw = 1'b0; step(3);
        bus.btn_raw = 1'b1; step(12);
        check_int("bounce_no_press", press_cnt - pc, 0);
        check_bit("bounce_level", bus.btn_level, 1'b0);
        bus.btn_raw = 1'b0; step(10);
        bus.btn_raw = 1'b1; step(2);
        bus.btn_raw = 1'b0; step(2);
        bus.btn_raw = 1'b1; step(14);
        check_int("bounce_press_once", press_cnt - pc, 1);
        check_int("bounce_release_once", rel_cnt - rc, 1);
        check_bit("bounce_toggle", bus.toggle, 1'b0);

        // 4: long press
        pc = press_cnt; rc = rel_cnt; lc = long_cnt;
        t0 = cyc;
        bus.btn_raw = 1'b0;
        step(37);
        check_int("long_count", long_cnt - lc, 1);
        check_int("long_after_press", long_cyc - press_cyc, 10);
        check_int("long_press_latency", press_cyc - t0, 7);
        bus.btn_raw = 1'b1;
        step(12);
        check_int("long_count_after_release", long_cnt - lc, 1);
        check_int("long_release_count", rel_cnt - rc, 1);
        check_bit("long_toggle", bus.toggle, 1'b1);

        // 5: locked press, then unlocked press
        pc = press_cnt; rc = rel_cnt; lc = long_cnt;
        bus.lock = 1'b1;
        bus.btn_raw = 1'b0;
        step(10);
        check_bit("lock_level", bus.btn_level, 1'b1);
        step(22);
        bus.btn_raw = 1'b1;
        step(12);
        check_int("lock_no_press", press_cnt - pc, 0);
        check_int("lock_no_long", long_cnt - lc, 0);
        check_int("lock_release", rel_cnt - rc, 1);
        check_bit("lock_toggle_held", bus.toggle, 1'b1);
        bus.lock = 1'b0;
        bus.btn_raw = 1'b0;
        step(12);
        check_int("unlock_press", press_cnt - pc, 1);
        check_bit("unlock_toggle", bus.toggle, 1'b0);
        bus.btn_raw = 1'b1;
        step(12);

        // 6: reset while pressed and held
        pc = press_cnt;
        bus.btn_raw = 1'b0;
        step(12);
        check_bit("pre_reset_level", bus.btn_level, 1'b1);
        rst = 1'b0;
        step(1);
        check_all_zero("midreset");
        tr = cyc;
        rst = 1'b1;
        step(10);
        check_int("repress_count", press_cnt - pc, 2);
        check_int("repress_latency", press_cyc - tr, 7);
        check_bit("repress_toggle", bus.toggle, 1'b1);
        bus.btn_raw = 1'b1;
        step(12);
        check_bit("final_level", bus.btn_level, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
